button_debouncer: RTL and testbench

Input conditioning stage for the board push-buttons. It feeds the LED up/down counter and any other button consumer. The block synchronises the raw active-low button pins, filters contact bounce with a per-button stability counter, and emits a clean debounced level plus single-cycle press and release pulses. Downstream logic counts these pulses directly, with no further edge detection.

---
 rtl/button_debouncer.sv | 162 ++++++++++++++++
 tb/tb_button_debouncer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: per-button two-flop synchroniser, stability-counter
// debounce filter and registered press/release pulse generation for
// active-low push-button pins.
// Optional feature: define BTN_AUTOREPEAT_EN to add a per-button auto-repeat
// FSM that re-issues btn_press while the button stays held.
module button_debouncer #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] w_button,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_debouncer: illegal parameter value");
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;
  localparam logic [RPT_W-1:0] DLY_END = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_END = RPT_W'(REPEAT_PERIOD - 1);
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_done;
    logic             w_rise;
    logic             w_fall;
    logic             w_rpt_pulse;

    // The filter accepts the synchronised state once it has differed from
    // the debounced level for DEBOUNCE_CYCLES consecutive cycles.
    assign w_done = (r_sync2 != r_level) && (r_cnt == CNT_MAX);
    assign w_rise = w_done && r_sync2;
    assign w_fall = w_done && !r_sync2;

    // Two-flop synchroniser on the inverted (active-high pressed) pin.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= ~w_button[i];
        r_sync2 <= r_sync1;
      end
    end

    // Stability counter: any agreement with the current level restarts it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Registered pulses, aligned with the cycle the debounced level changes.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rise | w_rpt_pulse;
        r_release <= w_fall;
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    rpt_state_t       r_state;
    rpt_state_t       w_state_nxt;
    logic [RPT_W-1:0] r_rcnt;
    logic [RPT_W-1:0] w_rcnt_nxt;

    // Auto-repeat state and timer registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
      end
    end

    // Repeat timing: a debounced release wins over a due repeat pulse.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_rpt_pulse = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_DELAY;
            w_rcnt_nxt  = '0;
          end
        end
        ST_DELAY: begin
          if (w_fall) begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == DLY_END) begin
            w_rpt_pulse = 1'b1;
            w_state_nxt = ST_REPEAT;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (w_fall) begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == PER_END) begin
            w_rpt_pulse = 1'b1;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end
`else
    assign w_rpt_pulse = 1'b0;
`endif

    assign btn_level[i]   = r_level;
    assign btn_press[i]   = r_press;
    assign btn_release[i] = r_release;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: table vectors, directed corner sequences and random
// stimulus against a sample-window reference model of button_debouncer.
module tb_button_debouncer;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] w_button = 2'b00;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  button_debouncer #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .w_button(w_button),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Reference model: level flips once the last D synchronised samples
  // (raw samples delayed by two edges) all disagree with it.
  bit           m_hist [N][64];
  int           m_edge;
  logic [N-1:0] m_level, m_press, m_release;
`ifdef BTN_AUTOREPEAT_EN
  int           m_p  [N];
  bit           m_pv [N];
`endif

  task automatic model_reset();
    m_edge    = 0;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
`ifdef BTN_AUTOREPEAT_EN
    for (int b = 0; b < N; b++) begin
      m_p[b]  = 0;
      m_pv[b] = 1'b0;
    end
`endif
  endtask

  task automatic model_edge();
    bit flip;
    bit prev;
    bit rpt;
    m_edge++;
    for (int b = 0; b < N; b++) begin
      m_hist[b][m_edge % 64] = ~w_button[b];
      prev = m_level[b];
      flip = (m_edge >= D + 2);
      if (flip)
        for (int k = 2; k <= D + 1; k++)
          if (m_hist[b][(m_edge - k) % 64] == prev) flip = 1'b0;
      rpt = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      if (prev && !flip && m_pv[b] && (m_edge - m_p[b]) >= RD &&
          ((m_edge - m_p[b] - RD) % RP) == 0)
        rpt = 1'b1;
      if (flip && !prev) begin
        m_p[b]  = m_edge;
        m_pv[b] = 1'b1;
      end
`endif
      m_press[b]   = (flip && !prev) || rpt;
      m_release[b] = flip && prev;
      if (flip) m_level[b] = !prev;
    end
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_level"}, btn_level, 2'b00);
    chk({name, "_press"}, btn_press, 2'b00);
    chk({name, "_release"}, btn_release, 2'b00);
  endtask

  // One clock edge: advance the model, then compare #1 after the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("model_level", btn_level, m_level);
    chk("model_press", btn_press, m_press);
    chk("model_release", btn_release, m_release);
  endtask

  task automatic settle(input logic [N-1:0] w, input int n);
    w_button = w;
    repeat (n) tick();
  endtask

  typedef struct {
    logic [N-1:0] w;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clean press then release of bit 0, one record per clock edge.
    tbl[0]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    tbl[2]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    tbl[3]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b10, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{2'b10, 2'b01, 2'b01, 2'b00};
    tbl[6]  = '{2'b10, 2'b01, 2'b00, 2'b00};
    tbl[7]  = '{2'b11, 2'b01, 2'b00, 2'b00};
    tbl[8]  = '{2'b11, 2'b01, 2'b00, 2'b00};
    tbl[9]  = '{2'b11, 2'b01, 2'b00, 2'b00};
    tbl[10] = '{2'b11, 2'b01, 2'b00, 2'b00};
    tbl[11] = '{2'b11, 2'b01, 2'b00, 2'b00};
    tbl[12] = '{2'b11, 2'b00, 2'b00, 2'b01};
    tbl[13] = '{2'b11, 2'b00, 2'b00, 2'b00};

    model_reset();

    // Held across reset: both buttons pressed while reset is high.
    repeat (3) begin
      tick();
      chk_zero("in_reset");
    end
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("held_rst_level", btn_level, (c >= 6) ? 2'b11 : 2'b00);
      chk("held_rst_press", btn_press, (c == 6) ? 2'b11 : 2'b00);
    end
    w_button = 2'b11;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("rel_both_release", btn_release, (c == 6) ? 2'b11 : 2'b00);
    end

    // Table-driven clean press/release.
    for (int k = 0; k < 14; k++) begin
      w_button = tbl[k].w;
      tick();
      chk($sformatf("tbl%0d_level", k), btn_level, tbl[k].lvl);
      chk($sformatf("tbl%0d_press", k), btn_press, tbl[k].prs);
      chk($sformatf("tbl%0d_release", k), btn_release, tbl[k].rel);
    end
    settle(2'b11, 4);

    // Simultaneous press on both bits.
    w_button = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("simul_press", btn_press, (c == 6) ? 2'b11 : 2'b00);
    end
    settle(2'b11, 10);

    // Bounce on bit 1: 2-cycle toggles for 20 cycles, then held pressed.
    for (int c = 0; c < 20; c++) begin
      w_button = {((c / 2) % 2 == 0) ? 1'b0 : 1'b1, 1'b1};
      tick();
      chk("bounce_quiet_press", btn_press, 2'b00);
      chk("bounce_quiet_level", btn_level, 2'b00);
    end
    w_button = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("bounce_press", btn_press, (c == 6) ? 2'b10 : 2'b00);
    end
    settle(2'b11, 10);

    // Auto-repeat: hold bit 0 for 30 cycles after the press pulse.
    begin : rpt_seq
      int p_edge;
      int rel_edge;
      int rels;
      int offs[$];
      int exp_offs[$];
`ifdef BTN_AUTOREPEAT_EN
      exp_offs = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34};
`else
      exp_offs = '{0};
`endif
      p_edge = -1;
      rel_edge = -1;
      rels = 0;
      w_button = 2'b10;
      for (int e = 1; e <= 70; e++) begin
        tick();
        if (btn_press[0]) begin
          if (p_edge < 0) p_edge = e;
          offs.push_back(e - p_edge);
        end
        if (btn_release[0]) begin
          rels++;
          rel_edge = e - p_edge;
        end
        if (p_edge >= 0 && e == p_edge + 30) w_button = 2'b11;
      end
      chk_int("rpt_first_edge", p_edge, 6);
      chk_int("rpt_count", offs.size(), exp_offs.size());
      for (int i = 0; i < offs.size() && i < exp_offs.size(); i++)
        chk_int($sformatf("rpt_offset%0d", i), offs[i], exp_offs[i]);
      chk_int("rpt_release_count", rels, 1);
      chk_int("rpt_release_offset", rel_edge, 36);
    end
    settle(2'b11, 4);

    // Reset mid-filter: bit 0 counter at 2, released during reset.
    w_button = 2'b10;
    repeat (4) tick();
    reset = 1'b1;
    w_button = 2'b11;
    model_reset();
    #1;
    chk_zero("midfilt_rst");
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_zero("midfilt_after");
    end

    // Asynchronous reset while both levels are high.
    settle(2'b00, 7);
    chk("pre_async_level", btn_level, 2'b11);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_zero("async_rst");
    w_button = 2'b11;
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk_zero("async_after");
    end

    // Randomised hold lengths per bit, occasional resets.
    begin : rand_phase
      int hold[N];
      logic [N-1:0] wv;
      wv = w_button;
      for (int b = 0; b < N; b++) hold[b] = 0;
      for (int c = 0; c < 1500; c++) begin
        for (int b = 0; b < N; b++) begin
          if (hold[b] == 0) begin
            wv[b] = 1'($urandom_range(0, 1));
            hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                  : int'($urandom_range(1, 6));
          end
          hold[b]--;
        end
        w_button = wv;
        if ($urandom_range(0, 299) == 0) begin
          reset = 1'b1;
          model_reset();
          #1;
          chk_zero("rand_rst");
          tick();
          tick();
          reset = 1'b0;
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
